// File: rtl/multiword_add_seq.sv
// Multi-chunk adder: slices WORDS*WIDTH-bit operands into WIDTH-bit chunks and
// ripples the carry through a register, one chunk per cycle. MWA_SUB_EN adds a 'sub' input.
`ifndef WIDTH
`define WIDTH 8
`endif

module multiword_add_seq #(
   parameter int WIDTH = `WIDTH,
   parameter int WORDS = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
`ifdef MWA_SUB_EN
   input  logic                     sub,
`endif
   input  logic [WIDTH*WORDS-1:0]   a,
   input  logic [WIDTH*WORDS-1:0]   b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH*WORDS:0]     sum
);

   localparam int CW = $clog2(WORDS) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                   state;
   logic [WIDTH*WORDS-1:0]   a_reg;
   logic [WIDTH*WORDS-1:0]   b_reg;
   logic [WIDTH*WORDS:0]     sum_reg;
   logic                     carry;
   logic [CW-1:0]            cnt;

   logic [WIDTH-1:0]         x;
   logic [WIDTH-1:0]         y;
   logic [WIDTH-1:0]         p_lo;
   logic                     p_co;
   logic [WIDTH-1:0]         q_lo;
   logic                     q_co;
   logic                     next_carry;

   // Select the chunk addressed by the counter with constant-index slices
   always_comb begin
      x = '0;
      y = '0;
      for (int k = 0; k < WORDS; k++) begin
         if (cnt == CW'(k)) begin
            x = a_reg[k*WIDTH +: WIDTH];
            y = b_reg[k*WIDTH +: WIDTH];
         end
      end
   end

   adder_cra #(.WIDTH(WIDTH)) u_add_xy (
      .a    (x),
      .b    (y),
      .cin  (1'b0),
      .s    (p_lo),
      .cout (p_co)
   );

   adder_cra #(.WIDTH(WIDTH)) u_add_carry (
      .a    (p_lo),
      .b    ({WIDTH{1'b0}}),
      .cin  (carry),
      .s    (q_lo),
      .cout (q_co)
   );

   // p_co and q_co are mutually exclusive, so OR gives the chunk carry-out
   assign next_carry = p_co | q_co;
   assign sum        = sum_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         sum_reg   <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_reg    <= a;
`ifdef MWA_SUB_EN
                  b_reg    <= sub ? ~b : b;
                  carry    <= sub;
`else
                  b_reg    <= b;
                  carry    <= 1'b0;
`endif
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               for (int k = 0; k < WORDS; k++) begin
                  if (cnt == CW'(k)) sum_reg[k*WIDTH +: WIDTH] <= q_lo;
               end
               carry <= next_carry;
               cnt   <= cnt + 1'b1;
               if (cnt == CW'(WORDS - 1)) begin
                  sum_reg[WIDTH*WORDS] <= next_carry;
                  out_valid            <= 1'b1;
                  state                <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// Plain ripple-carry adder used for each chunk step.
module adder_cra #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   logic [WIDTH:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = cin;
      for (int i = 0; i < WIDTH; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      cout = c[WIDTH];
   end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Randomized self-checking bench for multiword_add_seq with a cycle-level
// reference model of the handshake timing and exact arithmetic result.
module tb_multiword_add_seq;

   localparam int WIDTH = 8;
   localparam int WORDS = 4;
   localparam int N     = WIDTH * WORDS;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          sub = 1'b0;
   logic [N-1:0]  a = '0;
   logic [N-1:0]  b = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [N:0]    sum;

   int            vectors = 0;
   int            miscompares = 0;

   logic [N:0]    res[$];
   bit            rand_ready = 1'b0;

   int            cyc = 0;
   bit            pend = 1'b0;
   int            acc_cyc = 0;
   logic [N:0]    exp_sum = '0;
   bit            rst_seen = 1'b0;
   bit            exp_ov;

   multiword_add_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
`ifdef MWA_SUB_EN
      .sub       (sub),
`endif
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum)
   );

   always #5 clk = ~clk;

   // Exact result of the operation: A+B, or A-B+2^N so the MSB flags "no borrow"
   function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
      logic [N:0] r;
      if (s) r = {1'b0, x} + {1'b1, {N{1'b0}}} - {1'b0, y};
      else   r = {1'b0, x} + {1'b0, y};
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [N:0] act, input logic [N:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic timeoutFail(input string name);
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: timed out at cycle %0d", name, cyc);
   endtask

   // Reference model and compare process, sampled on the falling edge
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         pend     = 1'b0;
         rst_seen = 1'b1;
      end else begin
         exp_ov = pend && (cyc >= acc_cyc + WORDS + 1);
         checkOutput("out_valid", {{N{1'b0}}, out_valid}, {{N{1'b0}}, exp_ov});
         checkOutput("in_ready", {{N{1'b0}}, in_ready}, {{N{1'b0}}, !pend});
         if (rst_seen) checkOutput("sum_after_reset", sum, '0);
         rst_seen = 1'b0;
         if (exp_ov) checkOutput("sum", sum, exp_sum);
         if (exp_ov && out_ready) begin
            res.push_back(sum);
            pend = 1'b0;
         end else if (!pend && in_valid) begin
            pend    = 1'b1;
            acc_cyc = cyc;
            exp_sum = model(a, b, sub);
         end
      end
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic applyStimulus(input logic [N-1:0] av, input logic [N-1:0] bv, input logic sv);
      @(posedge clk);
      #1;
      a        = av;
      b        = bv;
      sub      = sv;
      in_valid = 1'b1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            a        = N'($urandom());
            b        = N'($urandom());
            return;
         end
      end
      in_valid = 1'b0;
      timeoutFail("accept");
   endtask

   task automatic waitResults(input int n);
      for (int t = 0; t < 2000; t++) begin
         if (res.size() >= n) return;
         @(negedge clk);
      end
      timeoutFail("result");
   endtask

   task automatic runOne(input string name, input logic [N-1:0] av, input logic [N-1:0] bv,
                         input logic sv, input logic [N:0] lit);
      int idx;
      idx = res.size();
      applyStimulus(av, bv, sv);
      waitResults(idx + 1);
      if (res.size() > idx) checkOutput(name, res[idx], lit);
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      logic         rs;
      int           idx;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);

      $display("[TB] directed operations");
      runOne("basic_add",   32'h00000001, 32'h00000002, 1'b0, 33'h000000003);
      runOne("carry_chain", 32'hFFFFFFFF, 32'h00000001, 1'b0, 33'h100000000);
      runOne("max_ops",     32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33'h1FFFFFFFE);

      $display("[TB] backpressure with in_valid held");
      idx       = res.size();
      out_ready = 1'b0;
      applyStimulus(32'h12345678, 32'h9ABCDEF0, 1'b0);
      fork
         begin
            for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
            repeat (10) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
         applyStimulus(32'hDEADBEEF, 32'h21524111, 1'b0);
      join
      waitResults(idx + 2);
      if (res.size() >= idx + 2) begin
         checkOutput("bp_first",  res[idx],     33'h0ACF13568);
         checkOutput("bp_second", res[idx + 1], 33'h100000000);
      end

      $display("[TB] reset during RUN");
      idx = res.size();
      applyStimulus(32'hAAAAAAAA, 32'h55555555, 1'b0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      runOne("after_reset", 32'h00000005, 32'h00000007, 1'b0, 33'h00000000C);

`ifdef MWA_SUB_EN
      $display("[TB] subtract mode");
      runOne("sub_no_borrow", 32'h00000010, 32'h00000001, 1'b1, 33'h10000000F);
      runOne("sub_borrow",    32'h00000000, 32'h00000001, 1'b1, 33'h0FFFFFFFF);
      runOne("add_with_sub0", 32'h00000010, 32'h00000001, 1'b0, 33'h000000011);
`endif

      $display("[TB] randomized operations");
      rand_ready = 1'b1;
      idx        = res.size();
      for (int i = 0; i < 40; i++) begin
         ra = ($urandom_range(0, 4) == 0) ? '1 : N'($urandom());
         rb = ($urandom_range(0, 4) == 0) ? '1 : N'($urandom());
`ifdef MWA_SUB_EN
         rs = 1'($urandom_range(0, 1));
`else
         rs = 1'b0;
`endif
         applyStimulus(ra, rb, rs);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      rand_ready = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      waitResults(idx + 40);
      repeat (3) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
